store_buffer: RTL and testbench

- FIFO store buffer between the pipeline MEM stage and the single-port data memory (`mem`).
- Accepts D/W/B stores from the pipeline and queues them.
- Drains the queue to memory one store per cycle, whenever no load owns the shared address port.
- Loads get priority on the port; a load stalls only while a queued store targets the same doubleword.

---
 rtl/store_buffer_if.sv | 37 +++
 rtl/store_buffer.sv | 142 ++++++++++++++
 tb/tb_store_buffer.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Pipeline/memory-side signal bundle of the store buffer. The slave modport is the
// buffer itself; the master modport is the surrounding MEM stage plus data memory.
interface store_buffer_if #(
    parameter int N = 64
);
    logic         st_valid;
    logic [1:0]   st_size;
    logic [N-1:0] st_addr;
    logic [N-1:0] st_data;
    logic         st_ready;
    logic         ld_valid;
    logic [N-1:0] ld_addr;
    logic         ld_dword;
    logic [N-1:0] ld_data;
    logic         ld_stall;
    logic         flush;
    logic         empty;
    logic [1:0]   mem_memwrite;
    logic         mem_dword;
    logic [N-1:0] mem_dataadr;
    logic [N-1:0] mem_writedata;
    logic [N-1:0] mem_readdata;

    modport slave (
        input  st_valid, st_size, st_addr, st_data, ld_valid, ld_addr, ld_dword, flush,
               mem_readdata,
        output st_ready, ld_data, ld_stall, empty, mem_memwrite, mem_dword, mem_dataadr,
               mem_writedata
    );

    modport master (
        output st_valid, st_size, st_addr, st_data, ld_valid, ld_addr, ld_dword, flush,
               mem_readdata,
        input  st_ready, ld_data, ld_stall, empty, mem_memwrite, mem_dword, mem_dataadr,
               mem_writedata
    );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer sharing the data-memory port with loads (loads win unless they hit a queued dword).
// Optional STB_PERF_EN adds saturating perf_stall / perf_full counters.
module store_buffer #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    store_buffer_if.slave bus
`ifdef STB_PERF_EN
    ,
    output logic [31:0]   perf_stall,
    output logic [31:0]   perf_full
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {PORT_IDLE, PORT_LOAD, PORT_DRAIN} port_e;

    typedef struct packed {
        logic [1:0]   size;
        logic [N-1:0] addr;
        logic [N-1:0] data;
    } entry_t;

    entry_t           entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             hazard, push, pop;
    port_e            port_sel;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && entries_q[i].addr[N-1:3] == bus.ld_addr[N-1:3]) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && bus.ld_valid;
    end

    // The port is held idle during reset so a stale queue cannot write memory at the reset edge.
    always_comb begin
        port_sel = PORT_IDLE;
        if (!reset_n) begin
            port_sel = PORT_IDLE;
        end else if (bus.ld_valid && !hazard) begin
            port_sel = PORT_LOAD;
        end else if (count_q != '0) begin
            port_sel = PORT_DRAIN;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        bus.mem_memwrite  = 2'd0;
        bus.mem_dword     = 1'b0;
        bus.mem_dataadr   = '0;
        bus.mem_writedata = '0;
        bus.ld_data       = '0;
        bus.ld_stall      = 1'b0;
        case (port_sel)
            PORT_LOAD: begin
                bus.mem_dataadr = bus.ld_addr;
                bus.mem_dword   = bus.ld_dword;
                bus.ld_data     = bus.mem_readdata;
            end
            PORT_DRAIN: begin
                bus.mem_dataadr   = entries_q[head_q].addr;
                bus.mem_memwrite  = entries_q[head_q].size;
                bus.mem_writedata = entries_q[head_q].data;
                bus.ld_stall      = bus.ld_valid;
            end
            default: ;
        endcase
    end

    assign bus.st_ready = !reset_n || ((count_q < CW'(DEPTH)) && !bus.flush);
    assign bus.empty    = !reset_n || (count_q == '0);

    // Size 0 completes the handshake but never occupies an entry.
    assign push = reset_n && bus.st_valid && bus.st_ready && (bus.st_size != 2'd0);
    assign pop  = (port_sel == PORT_DRAIN);

    always_comb begin
        head_d  = pop  ? PW'(head_q + 1'b1) : head_q;
        tail_d  = push ? PW'(tail_q + 1'b1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: entry storage is not reset; valid_q alone decides whether an entry's contents matter.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[tail_q] <= {bus.st_size, bus.st_addr, bus.st_data};
        end
    end

`ifdef STB_PERF_EN
    logic [31:0] perf_stall_q, perf_full_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_stall_q <= '0;
            perf_full_q  <= '0;
        end else begin
            if (bus.ld_stall && perf_stall_q != 32'hFFFF_FFFF) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (bus.st_valid && !bus.st_ready && perf_full_q != 32'hFFFF_FFFF) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_full  = perf_full_q;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a byte-addressed memory model on the port, a
// program-order reference memory for load results, and a queue of expected writes.
module tb_store_buffer;
    localparam int N     = 64;
    localparam int DEPTH = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    store_buffer_if #(.N(N)) bus ();

`ifdef STB_PERF_EN
    logic [31:0] perf_stall, perf_full;
`endif

    store_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus)
`ifdef STB_PERF_EN
        ,
        .perf_stall(perf_stall),
        .perf_full (perf_full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t      exp_q[$];
    int       checks = 0;
    int       errors = 0;
    bit [7:0] phys_mem [longint];
    bit [7:0] ref_mem  [longint];
    int       mem_gen = 0;

    // Size encoding: 1=word, 2=byte, 3=doubleword; little-endian bytes.
    function automatic void mem_write(bit to_ref, logic [1:0] size, logic [63:0] addr,
                                      logic [63:0] data);
        longint base;
        int     nb;
        case (size)
            2'd1:    begin base = longint'(addr & ~64'h3); nb = 4; end
            2'd2:    begin base = longint'(addr);          nb = 1; end
            default: begin base = longint'(addr & ~64'h7); nb = 8; end
        endcase
        for (int i = 0; i < nb; i++) begin
            if (to_ref) ref_mem[base + i] = data[8*i +: 8];
            else        phys_mem[base + i] = data[8*i +: 8];
        end
    endfunction

    // Word reads are zero-extended.
    function automatic logic [63:0] mem_read(bit from_ref, logic [63:0] addr, logic dword);
        longint      base;
        int          nb;
        logic [63:0] r;
        base = dword ? longint'(addr & ~64'h7) : longint'(addr & ~64'h3);
        nb   = dword ? 8 : 4;
        r    = '0;
        for (int i = 0; i < nb; i++) begin
            if (from_ref) r[8*i +: 8] = ref_mem.exists(base + i) ? ref_mem[base + i] : 8'h00;
            else          r[8*i +: 8] = phys_mem.exists(base + i) ? phys_mem[base + i] : 8'h00;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset_n && bus.mem_memwrite != 2'd0) begin
            mem_write(1'b0, bus.mem_memwrite, bus.mem_dataadr, bus.mem_writedata);
            mem_gen++;
        end
    end

    always @(bus.mem_dataadr or bus.mem_dword or mem_gen) begin
        bus.mem_readdata = mem_read(1'b0, bus.mem_dataadr, bus.mem_dword);
    end

    // Every memory write must match the oldest outstanding accepted store.
    always @(negedge clk) begin
        if (reset_n && bus.mem_memwrite != 2'd0) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got size=%0d addr=%h data=%h, expected no write",
                         bus.mem_memwrite, bus.mem_dataadr, bus.mem_writedata);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_memwrite !== e.size || bus.mem_dataadr !== e.addr ||
                    bus.mem_writedata !== e.data || bus.mem_dword !== 1'b0) begin
                    errors++;
                    $display("FAIL write_order: got size=%0d addr=%h data=%h dword=%b, expected size=%0d addr=%h data=%h dword=0",
                             bus.mem_memwrite, bus.mem_dataadr, bus.mem_writedata, bus.mem_dword,
                             e.size, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(bit v, logic [1:0] size, logic [63:0] addr, logic [63:0] data);
        bus.st_valid = v;
        bus.st_size  = size;
        bus.st_addr  = addr;
        bus.st_data  = data;
    endtask

    task automatic set_load(bit v, logic [63:0] addr, bit dword);
        bus.ld_valid = v;
        bus.ld_addr  = addr;
        bus.ld_dword = dword;
    endtask

    task automatic sb_push(logic [1:0] size, logic [63:0] addr, logic [63:0] data);
        if (size != 2'd0) begin
            exp_q.push_back('{size: size, addr: addr, data: data});
            mem_write(1'b1, size, addr, data);
        end
    endtask

    task automatic wait_empty(int budget, string name);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (bus.empty === 1'b1) seen = 1'b1;
            else next_cycle();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: empty stayed 0 for %0d cycles, expected 1", name, budget);
        end
        next_cycle();
    endtask

    // Holds a load until it completes; verifies data, stall count and zero data while stalled.
    task automatic run_load(logic [63:0] addr, bit dword, int exp_stalls, string name);
        logic [63:0] exp_data;
        int          stalls = 0;
        bit          done   = 1'b0;
        exp_data = mem_read(1'b1, addr, dword);
        set_load(1'b1, addr, dword);
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (bus.ld_stall === 1'b1) begin
                stalls++;
                checks++;
                if (bus.ld_data !== 64'h0) begin
                    errors++;
                    $display("FAIL %s_stall_data: got %h, expected 0", name, bus.ld_data);
                end
            end else begin
                done = 1'b1;
                checks++;
                if (bus.ld_data !== exp_data) begin
                    errors++;
                    $display("FAIL %s_data: got %h, expected %h", name, bus.ld_data, exp_data);
                end
                checks++;
                if (stalls != exp_stalls) begin
                    errors++;
                    $display("FAIL %s_stalls: got %0d, expected %0d", name, stalls, exp_stalls);
                end
            end
            next_cycle();
        end
        set_load(1'b0, '0, 1'b0);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: load still stalled after 8 cycles, expected completion", name);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.st_ready, bus.empty, bus.ld_stall, bus.mem_memwrite} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_during: got ready/empty/stall/memwrite=%b, expected 11000",
                     {bus.st_ready, bus.empty, bus.ld_stall, bus.mem_memwrite});
        end
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.st_ready, bus.empty, bus.ld_stall, bus.mem_memwrite} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_after: got ready/empty/stall/memwrite=%b, expected 11000",
                     {bus.st_ready, bus.empty, bus.ld_stall, bus.mem_memwrite});
        end
        next_cycle();
    endtask

    task automatic test_dword_store();
        set_store(1'b1, 2'd3, 64'h10, 64'h1122334455667788);
        @(negedge clk);
        checks++;
        if (bus.st_ready !== 1'b1) begin
            errors++;
            $display("FAIL dword_ready: got %b, expected 1", bus.st_ready);
        end
        sb_push(2'd3, 64'h10, 64'h1122334455667788);
        next_cycle();
        set_store(1'b0, 2'd0, '0, '0);
        @(negedge clk);
        checks++;
        if (bus.mem_memwrite !== 2'd3 || bus.mem_dataadr !== 64'h10) begin
            errors++;
            $display("FAIL dword_latency: got memwrite=%0d addr=%h, expected memwrite=3 addr=10",
                     bus.mem_memwrite, bus.mem_dataadr);
        end
        next_cycle();
        run_load(64'h10, 1'b1, 0, "dword_load");
    endtask

    task automatic test_back_to_back();
        set_load(1'b1, 64'h400, 1'b1);
        for (int i = 0; i < 5; i++) begin
            set_store(1'b1, 2'd2, 64'h30 + 64'(i), 64'hA0 + 64'(i));
            @(negedge clk);
            checks++;
            if (bus.st_ready !== (i < 4)) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b, expected %b", i, bus.st_ready, (i < 4));
            end
            checks++;
            if (bus.ld_stall !== 1'b0 || bus.mem_memwrite !== 2'd0) begin
                errors++;
                $display("FAIL b2b_load_owns%0d: got stall=%b memwrite=%0d, expected 0 0",
                         i, bus.ld_stall, bus.mem_memwrite);
            end
            if (i < 4) sb_push(2'd2, 64'h30 + 64'(i), 64'hA0 + 64'(i));
            next_cycle();
        end
        set_store(1'b0, 2'd0, '0, '0);
        set_load(1'b0, '0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_memwrite !== 2'd2) begin
                errors++;
                $display("FAIL b2b_drain%0d: got memwrite=%0d, expected 2", c, bus.mem_memwrite);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL b2b_empty: got %b, expected 1", bus.empty);
        end
        next_cycle();
    endtask

    task automatic test_hazard();
        set_store(1'b1, 2'd1, 64'h20, 64'hCAFEF00D);
        @(negedge clk);
        sb_push(2'd1, 64'h20, 64'hCAFEF00D);
        next_cycle();
        set_store(1'b0, 2'd0, '0, '0);
        wait_empty(4, "hazard_setup");
        set_store(1'b1, 2'd1, 64'h24, 64'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (bus.st_ready !== 1'b1) begin
            errors++;
            $display("FAIL hazard_ready: got %b, expected 1", bus.st_ready);
        end
        sb_push(2'd1, 64'h24, 64'hDEADBEEF);
        next_cycle();
        set_store(1'b0, 2'd0, '0, '0);
        run_load(64'h20, 1'b0, 1, "hazard_load");
        run_load(64'h24, 1'b0, 0, "hazard_word");
    endtask

    task automatic test_load_priority();
        logic [63:0] exp_data;
        exp_data = mem_read(1'b1, 64'h100, 1'b1);
        set_load(1'b1, 64'h100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) set_store(1'b1, 2'd3, 64'h200 + 64'(8 * i), 64'h5A5A_0000_0000_0000 + 64'(i));
            else       set_store(1'b0, 2'd0, '0, '0);
            @(negedge clk);
            checks++;
            if (bus.ld_stall !== 1'b0 || bus.mem_memwrite !== 2'd0 || bus.ld_data !== exp_data) begin
                errors++;
                $display("FAIL prio_load%0d: got stall=%b memwrite=%0d data=%h, expected 0 0 %h",
                         i, bus.ld_stall, bus.mem_memwrite, bus.ld_data, exp_data);
            end
            if (i < 2) sb_push(2'd3, 64'h200 + 64'(8 * i), 64'h5A5A_0000_0000_0000 + 64'(i));
            next_cycle();
        end
        set_load(1'b0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.mem_memwrite !== 2'd3) begin
            errors++;
            $display("FAIL prio_drain: got memwrite=%0d, expected 3", bus.mem_memwrite);
        end
        next_cycle();
        wait_empty(4, "prio_empty");
    endtask

    task automatic test_reset_discard();
        set_load(1'b1, 64'h400, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_store(1'b1, 2'd2, 64'h800 + 64'(i), 64'h11 * 64'(i + 1));
            @(negedge clk);
            sb_push(2'd2, 64'h800 + 64'(i), 64'h11 * 64'(i + 1));
            next_cycle();
        end
        set_store(1'b0, 2'd0, '0, '0);
        set_load(1'b0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL discard_queued: got empty=%b, expected 0", bus.empty);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_memwrite !== 2'd0 || bus.st_ready !== 1'b1 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL discard_in_reset: got memwrite=%0d ready=%b empty=%b, expected 0 1 1",
                     bus.mem_memwrite, bus.st_ready, bus.empty);
        end
        exp_q.delete();
        next_cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_memwrite !== 2'd0 || bus.st_ready !== 1'b1 || bus.empty !== 1'b1) begin
                errors++;
                $display("FAIL discard_after%0d: got memwrite=%0d ready=%b empty=%b, expected 0 1 1",
                         c, bus.mem_memwrite, bus.st_ready, bus.empty);
            end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        set_load(1'b1, 64'h400, 1'b1);
        for (int i = 0; i < 2; i++) begin
            set_store(1'b1, 2'd3, 64'h300 + 64'(8 * i), 64'hF00D_0000_0000_0000 + 64'(i));
            @(negedge clk);
            sb_push(2'd3, 64'h300 + 64'(8 * i), 64'hF00D_0000_0000_0000 + 64'(i));
            next_cycle();
        end
        set_load(1'b0, '0, 1'b0);
        bus.flush = 1'b1;
        set_store(1'b1, 2'd3, 64'h310, 64'hBAD0_BAD0_BAD0_BAD0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus.st_ready !== 1'b0 || bus.mem_memwrite !== 2'd3) begin
                errors++;
                $display("FAIL flush_drain%0d: got ready=%b memwrite=%0d, expected 0 3",
                         c, bus.st_ready, bus.mem_memwrite);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (bus.empty !== 1'b1 || bus.st_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: got empty=%b ready=%b, expected 1 0", bus.empty, bus.st_ready);
        end
        next_cycle();
        bus.flush = 1'b0;
        set_store(1'b0, 2'd0, '0, '0);
    endtask

    task automatic test_illegal_size();
        set_store(1'b1, 2'd0, 64'h500, 64'h55);
        @(negedge clk);
        checks++;
        if (bus.st_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_ready: got %b, expected 1", bus.st_ready);
        end
        next_cycle();
        set_store(1'b0, 2'd0, '0, '0);
        @(negedge clk);
        checks++;
        if (bus.empty !== 1'b1 || bus.mem_memwrite !== 2'd0) begin
            errors++;
            $display("FAIL illegal_not_queued: got empty=%b memwrite=%0d, expected 1 0",
                     bus.empty, bus.mem_memwrite);
        end
        next_cycle();
    endtask

    initial begin
        bus.flush = 1'b0;
        set_store(1'b0, 2'd0, '0, '0);
        set_load(1'b0, '0, 1'b0);
        test_reset();
        test_dword_store();
        test_back_to_back();
        test_hazard();
        test_load_priority();
        test_reset_discard();
        test_flush();
        test_illegal_size();
        repeat (3) next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_writes: got %0d outstanding stores, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
